// File: rtl/random_arbiter_if.sv
// random_arbiter_if: requester-side and device-side signal bundle for random_arbiter.
//   Requester side : reqRead, reqWrite, reqDataIn (in to arbiter); grant, rspValid,
//                    rspData, rspError, busy (out of arbiter)
//   Device side    : devRead, devWrite, devDataIn (out of arbiter); devReadValid,
//                    devDataOut (in to arbiter)
//   slave  modport : the arbiter's view
//   master modport : the environment's view (clients plus random device)
interface random_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    reqRead;
  logic [NUM_REQ-1:0]    reqWrite;
  logic [NUM_REQ*32-1:0] reqDataIn;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rspValid;
  logic [31:0]           rspData;
  logic                  rspError;
  logic                  busy;
  logic                  devRead;
  logic                  devWrite;
  logic [31:0]           devDataIn;
  logic                  devReadValid;
  logic [31:0]           devDataOut;

  modport slave (
    input  reqRead, reqWrite, reqDataIn, devReadValid, devDataOut,
    output grant, rspValid, rspData, rspError, busy, devRead, devWrite, devDataIn
  );

  modport master (
    output reqRead, reqWrite, reqDataIn, devReadValid, devDataOut,
    input  grant, rspValid, rspData, rspError, busy, devRead, devWrite, devDataIn
  );
endinterface

// File: rtl/random_arbiter.sv
// random_arbiter: round-robin sharing of one random-number device among NUM_REQ
// requesters, one transaction in flight. Writes (seeds) take IDLE->ISSUE->IDLE;
// reads take IDLE->ISSUE->WAIT->RESP->IDLE and route the returned word to the owner.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : random_arbiter_if.slave (requester and device signals)
// Parameters:
//   NUM_REQ : number of requesters (2..8)
//   TIMEOUT : WAIT-cycle bound before a forced error response
// Optional feature: define RANDOM_ARB_TIMEOUT_EN to bound WAIT by TIMEOUT cycles;
// otherwise WAIT is unbounded and rspError stays 0.
module random_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  random_arbiter_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned CAND_W = PTR_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("random_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("random_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
  logic               is_wr, is_wr_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_n;
  logic [31:0]        rsp_data_q, rsp_data_n;
  logic               rsp_error_q, rsp_error_n;
  logic               busy_q, busy_n;
  logic               dev_read_q, dev_read_n;
  logic               dev_write_q, dev_write_n;
  logic [31:0]        dev_data_q, dev_data_n;

`ifdef RANDOM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] to_cnt, to_cnt_n;
`endif

  // Round-robin search: first requester at rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ
  logic [NUM_REQ-1:0] req_any;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [CAND_W-1:0]  cand;
  logic [31:0]        win_data;

  assign req_any = bus.reqRead | bus.reqWrite;

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = CAND_W'(rr_ptr) + CAND_W'(i);
      if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
      if (!win_found && req_any[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Winner's write-data slice
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) win_data = bus.reqDataIn[32*i +: 32];
    end
  end

  // Next-state and next-output logic; outputs are registered from these
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    is_wr_n     = is_wr;
    grant_n     = '0;
    rsp_valid_n = '0;
    rsp_data_n  = rsp_data_q;
    rsp_error_n = 1'b0;
    dev_read_n  = 1'b0;
    dev_write_n = 1'b0;
    dev_data_n  = dev_data_q;
`ifdef RANDOM_ARB_TIMEOUT_EN
    to_cnt_n    = to_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          state_n          = S_ISSUE;
          rr_ptr_n         = win_idx;
          grant_n[win_idx] = 1'b1;
          // A write wins over a read from the same requester
          is_wr_n          = bus.reqWrite[win_idx];
          if (bus.reqWrite[win_idx]) begin
            dev_write_n = 1'b1;
            dev_data_n  = win_data;
          end else begin
            dev_read_n  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (is_wr) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_WAIT;
`ifdef RANDOM_ARB_TIMEOUT_EN
          to_cnt_n = '0;
`endif
        end
      end
      S_WAIT: begin
        // devReadValid takes priority over a timeout in the same cycle
        if (bus.devReadValid) begin
          state_n             = S_RESP;
          rsp_valid_n[rr_ptr] = 1'b1;
          rsp_data_n          = bus.devDataOut;
        end
`ifdef RANDOM_ARB_TIMEOUT_EN
        else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n             = S_RESP;
          rsp_valid_n[rr_ptr] = 1'b1;
          rsp_data_n          = '0;
          rsp_error_n         = 1'b1;
        end else begin
          to_cnt_n = to_cnt + CNT_W'(1);
        end
`endif
      end
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      is_wr       <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      dev_read_q  <= 1'b0;
      dev_write_q <= 1'b0;
      dev_data_q  <= '0;
`ifdef RANDOM_ARB_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      is_wr       <= is_wr_n;
      grant_q     <= grant_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rsp_error_q <= rsp_error_n;
      busy_q      <= busy_n;
      dev_read_q  <= dev_read_n;
      dev_write_q <= dev_write_n;
      dev_data_q  <= dev_data_n;
`ifdef RANDOM_ARB_TIMEOUT_EN
      to_cnt      <= to_cnt_n;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.rspValid  = rsp_valid_q;
  assign bus.rspData   = rsp_data_q;
  assign bus.rspError  = rsp_error_q;
  assign bus.busy      = busy_q;
  assign bus.devRead   = dev_read_q;
  assign bus.devWrite  = dev_write_q;
  assign bus.devDataIn = dev_data_q;

endmodule

// File: tb/tb_random_arbiter.sv
// tb_random_arbiter: directed bench for random_arbiter with a 2-cycle-latency
// random-device model. Inputs and checks are aligned to the falling clock edge.
module tb_random_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;

  random_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  random_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic        dev_silent;
  logic        manual_valid;
  logic [31:0] manual_data;
  logic [31:0] dev_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},     32'(bus.grant),    32'h0);
    check({tag, "_rspValid"},  32'(bus.rspValid), 32'h0);
    check({tag, "_rspData"},   bus.rspData,       32'h0);
    check({tag, "_rspError"},  32'(bus.rspError), 32'h0);
    check({tag, "_busy"},      32'(bus.busy),     32'h0);
    check({tag, "_devRead"},   32'(bus.devRead),  32'h0);
    check({tag, "_devWrite"},  32'(bus.devWrite), 32'h0);
    check({tag, "_devDataIn"}, bus.devDataIn,     32'h0);
  endtask

  // Device model: returns dev_word 2 cycles after devRead; manual pulses override
  initial begin
    int   cnt;
    logic valid_m;
    cnt = 0;
    bus.devReadValid = 1'b0;
    bus.devDataOut   = '0;
    forever begin
      @(negedge clk);
      #1;
      valid_m = 1'b0;
      if (reset !== 1'b1) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) valid_m = 1'b1;
        end
        if (!dev_silent && bus.devRead) cnt = 2;
      end
      bus.devReadValid = valid_m | manual_valid;
      bus.devDataOut   = manual_valid ? manual_data : dev_word;
    end
  end

  initial begin
    int order [5];
    int ng;
    int last_c;
    order         = '{0, 1, 2, 3, 0};
    reset         = 1'b0;
    bus.reqRead   = '0;
    bus.reqWrite  = '0;
    bus.reqDataIn = '0;
    dev_silent    = 1'b0;
    manual_valid  = 1'b0;
    manual_data   = '0;
    dev_word      = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) cyc();
    check_all_zero("reset");
    reset = 1'b1;
    cyc();

    // Single read by req0
    bus.reqRead = 4'b0001;
    cyc();
    check("rd_grant",   32'(bus.grant),   32'h1);
    check("rd_devRead", 32'(bus.devRead), 32'h1);
    check("rd_busy",    32'(bus.busy),    32'h1);
    bus.reqRead = '0;
    cyc();
    check("rd_grant_pulse",   32'(bus.grant),   32'h0);
    check("rd_devRead_pulse", 32'(bus.devRead), 32'h0);
    cyc();
    check("rd_no_early_rsp", 32'(bus.rspValid), 32'h0);
    cyc();
    check("rd_rspValid", 32'(bus.rspValid), 32'h1);
    check("rd_rspData",  bus.rspData,       32'hDEAD_BEEF);
    check("rd_rspError", 32'(bus.rspError), 32'h0);
    cyc();
    check("rd_rsp_pulse", 32'(bus.rspValid), 32'h0);
    check("rd_idle_busy", 32'(bus.busy),     32'h0);
    check("rd_data_hold", bus.rspData,       32'hDEAD_BEEF);

    // Write by req2
    bus.reqWrite           = 4'b0100;
    bus.reqDataIn[95:64]   = 32'h1234_5678;
    cyc();
    check("wr_grant",     32'(bus.grant),    32'h4);
    check("wr_devWrite",  32'(bus.devWrite), 32'h1);
    check("wr_devRead",   32'(bus.devRead),  32'h0);
    check("wr_devDataIn", bus.devDataIn,     32'h1234_5678);
    bus.reqWrite = '0;
    cyc();
    check("wr_busy_low",   32'(bus.busy),     32'h0);
    check("wr_write_pulse", 32'(bus.devWrite), 32'h0);

    // All four reading continuously from reset: order 0,1,2,3,0, one grant per 5 cycles
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    bus.reqRead = 4'b1111;
    ng     = 0;
    last_c = 0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      cyc();
      if (bus.grant != '0) begin
        check($sformatf("rr_grant%0d", ng), 32'(bus.grant), 32'(1) << order[ng]);
        if (ng > 0) check($sformatf("rr_gap%0d", ng), 32'(c - last_c), 32'd5);
        last_c = c;
        ng++;
        bus.reqRead = bus.reqRead & ~bus.grant;
        if (ng == 5) bus.reqRead = '0;
      end
      if (bus.rspValid != '0) bus.reqRead = bus.reqRead | bus.rspValid;
    end
    check("rr_count", 32'(ng), 32'd5);
    repeat (5) cyc();

    // Requester 1 with read and write: write first, then read
    dev_word             = 32'h0BAD_F00D;
    bus.reqRead          = 4'b0010;
    bus.reqWrite         = 4'b0010;
    bus.reqDataIn[63:32] = 32'hCAFE_F00D;
    cyc();
    check("rw_grant_wr",  32'(bus.grant),    32'h2);
    check("rw_devWrite",  32'(bus.devWrite), 32'h1);
    check("rw_devRead0",  32'(bus.devRead),  32'h0);
    check("rw_devDataIn", bus.devDataIn,     32'hCAFE_F00D);
    bus.reqWrite = '0;
    cyc();
    check("rw_gap_grant", 32'(bus.grant), 32'h0);
    cyc();
    check("rw_grant_rd", 32'(bus.grant),   32'h2);
    check("rw_devRead",  32'(bus.devRead), 32'h1);
    bus.reqRead = '0;
    repeat (3) cyc();
    check("rw_rspValid", 32'(bus.rspValid), 32'h2);
    check("rw_rspData",  bus.rspData,       32'h0BAD_F00D);
    cyc();

    // Reset during WAIT, then a stray devReadValid
    dev_silent  = 1'b1;
    bus.reqRead = 4'b0100;
    cyc();
    check("rst_grant", 32'(bus.grant), 32'h4);
    bus.reqRead = '0;
    cyc();
    check("rst_wait_busy", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    cyc();
    reset        = 1'b1;
    manual_valid = 1'b1;
    manual_data  = 32'h55AA_55AA;
    cyc();
    manual_valid = 1'b0;
    check("rst_stray_rsp", 32'(bus.rspValid), 32'h0);
    cyc();
    check("rst_stray_rsp2",  32'(bus.rspValid), 32'h0);
    check("rst_stray_busy",  32'(bus.busy),     32'h0);
    check("rst_stray_data",  bus.rspData,       32'h0);
    dev_silent  = 1'b0;
    bus.reqRead = 4'b1111;
    cyc();
    check("rst_first_grant", 32'(bus.grant), 32'h1);
    bus.reqRead = '0;
    repeat (4) cyc();

    // devReadValid arriving in the last allowed WAIT cycle gives a normal response
    dev_silent  = 1'b1;
    bus.reqRead = 4'b1000;
    cyc();
    check("edge_grant", 32'(bus.grant), 32'h8);
    bus.reqRead = '0;
    repeat (TIMEOUT) cyc();
    check("edge_no_early", 32'(bus.rspValid), 32'h0);
    manual_valid = 1'b1;
    manual_data  = 32'hA5A5_0001;
    cyc();
    manual_valid = 1'b0;
    check("edge_rspValid", 32'(bus.rspValid), 32'h8);
    check("edge_rspError", 32'(bus.rspError), 32'h0);
    check("edge_rspData",  bus.rspData,       32'hA5A5_0001);
    cyc();

    // Silent device
    bus.reqRead = 4'b0010;
    cyc();
    check("to_grant", 32'(bus.grant), 32'h2);
    bus.reqRead = '0;
    repeat (TIMEOUT) cyc();
    check("to_no_early", 32'(bus.rspValid), 32'h0);
    cyc();
`ifdef RANDOM_ARB_TIMEOUT_EN
    check("to_rspValid", 32'(bus.rspValid), 32'h2);
    check("to_rspError", 32'(bus.rspError), 32'h1);
    check("to_rspData",  bus.rspData,       32'h0);
    cyc();
    check("to_idle", 32'(bus.busy), 32'h0);
`else
    check("to_none",   32'(bus.rspValid), 32'h0);
    check("to_busy",   32'(bus.busy),     32'h1);
    repeat (20) cyc();
    check("to_none_late", 32'(bus.rspValid), 32'h0);
    check("to_busy_late", 32'(bus.busy),     32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
